// File: rtl/stp_deser_if.sv
// rtl/stp_deser_if.sv - bit-stream input and word-output handshake bundle for stp_deser
// The slave modport is the deserializer side; the master modport is the line/decoder side.
interface stp_deser_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             in;
  logic             in_valid;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             out_ready;
  logic             busy;
  logic             overflow;
  logic             ovf_clr;

  modport master (
    output start, in, in_valid, out_ready, ovf_clr,
    input  data, data_valid, busy, overflow
  );

  modport slave (
    input  start, in, in_valid, out_ready, ovf_clr,
    output data, data_valid, busy, overflow
  );
endinterface

// File: rtl/stp_deser.sv
// rtl/stp_deser.sv - framed serial-to-parallel deserializer with one-entry output register
// Assembles WIDTH valid bits per word; start always (re)opens a frame and outranks completion.
module stp_deser #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit CONT      = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  stp_deser_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] data_q;
  logic             dv_q;
  logic             ovf_q;

  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;
  logic             complete;

  // A start discards any partial word, so the incoming bit shifts into a cleared register.
  always_comb begin
    sr_base = bus.start ? '0 : sr;
    if (MSB_FIRST) begin
      sr_next = {sr_base[WIDTH-2:0], bus.in};
    end else begin
      sr_next = {bus.in, sr_base[WIDTH-1:1]};
    end
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign complete = (state == SHIFT) && bus.in_valid && !bus.start && last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.start) begin
        state <= SHIFT;
        sr    <= bus.in_valid ? sr_next : '0;
        cnt   <= bus.in_valid ? CW'(1) : '0;
      end else if ((state == SHIFT) && bus.in_valid) begin
        sr <= sr_next;
        if (last_bit) begin
          cnt <= '0;
          if (!CONT) begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      // A word may load into a register that is being drained on this same edge.
      if (complete && (!dv_q || bus.out_ready)) begin
        data_q <= sr_next;
        dv_q   <= 1'b1;
      end else if (dv_q && bus.out_ready) begin
        dv_q <= 1'b0;
      end

      if (complete && dv_q && !bus.out_ready) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.busy       = (state == SHIFT);
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_stp_deser.sv
// tb/tb_stp_deser.sv - self-checking bench for stp_deser
// Four configurations share one input stream; words are predicted from the bit-order rules.
module tb_stp_deser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, din = 1'b0, in_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stp_deser_if #(.WIDTH(8))  ia ();
  stp_deser_if #(.WIDTH(8))  ib ();
  stp_deser_if #(.WIDTH(8))  ic ();
  stp_deser_if #(.WIDTH(32)) id ();

  assign ia.start = start; assign ia.in = din; assign ia.in_valid = in_valid;
  assign ia.out_ready = out_ready; assign ia.ovf_clr = ovf_clr;
  assign ib.start = start; assign ib.in = din; assign ib.in_valid = in_valid;
  assign ib.out_ready = out_ready; assign ib.ovf_clr = ovf_clr;
  assign ic.start = start; assign ic.in = din; assign ic.in_valid = in_valid;
  assign ic.out_ready = out_ready; assign ic.ovf_clr = ovf_clr;
  assign id.start = start; assign id.in = din; assign id.in_valid = in_valid;
  assign id.out_ready = out_ready; assign id.ovf_clr = ovf_clr;

  stp_deser #(.WIDTH(8),  .MSB_FIRST(1'b1), .CONT(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  stp_deser #(.WIDTH(8),  .MSB_FIRST(1'b0), .CONT(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  stp_deser #(.WIDTH(8),  .MSB_FIRST(1'b1), .CONT(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
  stp_deser #(.WIDTH(32), .MSB_FIRST(1'b1), .CONT(1'b1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(id));

  // Consumer-side log of accepted words
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [31:0] qd[$];
  int          qd_cyc[$];

  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (ia.data_valid) qa.push_back(ia.data);
      if (ib.data_valid) qb.push_back(ib.data);
      if (id.data_valid) begin
        qd.push_back(id.data);
        qd_cyc.push_back(cyc);
      end
    end
  end

  // Word rebuilt from transmitted bit sequence seq[0], seq[1], ...
  function automatic logic [63:0] model_word(input logic [63:0] seq, input int w, input bit msb);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) begin
      if (msb) r[w-1-i] = seq[i];
      else     r[i] = seq[i];
    end
    return r;
  endfunction

  // Bit sequence that makes an MSB-first receiver rebuild word
  function automatic logic [63:0] tx_seq(input logic [63:0] word, input int w);
    logic [63:0] s = '0;
    for (int i = 0; i < w; i++) s[i] = word[w-1-i];
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; in_valid = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    qa.delete(); qb.delete(); qd.delete(); qd_cyc.delete();
  endtask

  // Sends seq[0..n-1]; gap_mask[i] forces one idle cycle before bit i, plus 0..max_gap random idles.
  task automatic send_bits(input logic [63:0] seq, input int n, input bit with_start,
                           input logic [63:0] gap_mask, input int max_gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        int g;
        g = int'(gap_mask[i]) + int'($urandom_range(0, max_gap));
        for (int k = 0; k < g; k++) begin
          start = 1'b0; in_valid = 1'b0; din = 1'($urandom);
          step();
        end
      end
      start = with_start && (i == 0);
      din = seq[i];
      in_valid = 1'b1;
      step();
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1; in_valid = 1'b1; din = 1'b1;
    step(); step();
    checks++; if (ia.data !== 8'h0 || {ia.data_valid, ia.busy, ia.overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_a: data=%h dv/busy/ovf=%b%b%b expected 0", ia.data, ia.data_valid, ia.busy, ia.overflow); end
    checks++; if (ib.data !== 8'h0 || {ib.data_valid, ib.busy, ib.overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_b: data=%h dv/busy/ovf=%b%b%b expected 0", ib.data, ib.data_valid, ib.busy, ib.overflow); end
    checks++; if (ic.data !== 8'h0 || {ic.data_valid, ic.busy, ic.overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_c: data=%h dv/busy/ovf=%b%b%b expected 0", ic.data, ic.data_valid, ic.busy, ic.overflow); end
    checks++; if (id.data !== 32'h0 || {id.data_valid, id.busy, id.overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_d: data=%h dv/busy/ovf=%b%b%b expected 0", id.data, id.data_valid, id.busy, id.overflow); end
    do_reset();
  endtask

  task automatic test_msb_frame();
    do_reset();
    out_ready = 1'b1;
    send_bits(64'h4D, 7, 1'b1, 64'h0, 0);
    checks++; if (ia.busy !== 1'b1) begin errors++; $display("FAIL msb_busy_mid: got %b expected 1", ia.busy); end
    checks++; if (ia.data_valid !== 1'b0) begin errors++; $display("FAIL msb_early_valid: got %b expected 0", ia.data_valid); end
    send_bits(64'h4D >> 7, 1, 1'b0, 64'h0, 0);
    checks++; if (ia.data_valid !== 1'b1 || ia.data !== 8'hB2) begin
      errors++; $display("FAIL msb_word: dv=%b data=%h expected 1/b2", ia.data_valid, ia.data); end
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL msb_busy_end: got %b expected 0", ia.busy); end
    checks++; if (ib.data !== 8'h4D) begin errors++; $display("FAIL lsb_contig_word: got %h expected 4d", ib.data); end
    step();
    checks++; if (ia.data_valid !== 1'b0 || ia.data !== 8'hB2) begin
      errors++; $display("FAIL msb_consume: dv=%b data=%h expected 0/b2", ia.data_valid, ia.data); end
  endtask

  task automatic test_lsb_gaps();
    do_reset();
    out_ready = 1'b1;
    send_bits(64'h4D, 7, 1'b1, 64'h54, 0);
    checks++; if (ib.data_valid !== 1'b0 || ib.busy !== 1'b1) begin
      errors++; $display("FAIL lsb_gap_mid: dv=%b busy=%b expected 0/1", ib.data_valid, ib.busy); end
    send_bits(64'h4D >> 7, 1, 1'b0, 64'h0, 0);
    checks++; if (ib.data_valid !== 1'b1 || ib.data !== 8'h4D) begin
      errors++; $display("FAIL lsb_gap_word: dv=%b data=%h expected 1/4d", ib.data_valid, ib.data); end
    checks++; if (ia.data !== 8'hB2) begin errors++; $display("FAIL msb_gap_word: got %h expected b2", ia.data); end
    step();
    checks++; if (ib.data_valid !== 1'b0) begin errors++; $display("FAIL lsb_gap_pulse: got %b expected 0", ib.data_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    send_bits(tx_seq(64'hA5, 8), 8, 1'b1, 64'h0, 0);
    checks++; if (ic.data_valid !== 1'b1 || ic.data !== 8'hA5 || ic.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_first: dv=%b data=%h ovf=%b expected 1/a5/0", ic.data_valid, ic.data, ic.overflow); end
    send_bits(tx_seq(64'h3C, 8), 8, 1'b0, 64'h0, 0);
    checks++; if (ic.data_valid !== 1'b1 || ic.data !== 8'hA5 || ic.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop: dv=%b data=%h ovf=%b expected 1/a5/1", ic.data_valid, ic.data, ic.overflow); end
    checks++; if (ic.busy !== 1'b1) begin errors++; $display("FAIL cont_busy: got %b expected 1", ic.busy); end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    checks++; if (ic.overflow !== 1'b0 || ic.data_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_clear: ovf=%b dv=%b expected 0/1", ic.overflow, ic.data_valid); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (ic.data_valid !== 1'b0 || ic.data !== 8'hA5) begin
      errors++; $display("FAIL ovf_consume: dv=%b data=%h expected 0/a5", ic.data_valid, ic.data); end
    send_bits(tx_seq(64'h5A, 8), 8, 1'b0, 64'h0, 0);
    checks++; if (ic.data_valid !== 1'b1 || ic.data !== 8'h5A) begin
      errors++; $display("FAIL ovf_reload: dv=%b data=%h expected 1/5a", ic.data_valid, ic.data); end
    send_bits(tx_seq(64'hC3, 8), 7, 1'b0, 64'h0, 0);
    ovf_clr = 1'b1;
    send_bits(tx_seq(64'hC3, 8) >> 7, 1, 1'b0, 64'h0, 0);
    ovf_clr = 1'b0;
    checks++; if (ic.overflow !== 1'b1 || ic.data !== 8'h5A) begin
      errors++; $display("FAIL ovf_set_wins: ovf=%b data=%h expected 1/5a", ic.overflow, ic.data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    send_bits(tx_seq(64'hDEADBEEF, 32), 32, 1'b1, 64'h0, 0);
    send_bits(tx_seq(64'h01234567, 32), 32, 1'b0, 64'h0, 0);
    step();
    checks++; if (qd.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", qd.size()); end
    if (qd.size() == 2) begin
      checks++; if (qd[0] !== 32'hDEADBEEF || qd[1] !== 32'h01234567) begin
        errors++; $display("FAIL b2b_words: got %h %h expected deadbeef 01234567", qd[0], qd[1]); end
      checks++; if (qd_cyc[1] - qd_cyc[0] !== 32) begin
        errors++; $display("FAIL b2b_spacing: got %0d expected 32", qd_cyc[1] - qd_cyc[0]); end
    end
    checks++; if (id.overflow !== 1'b0 || id.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_flags: ovf=%b busy=%b expected 0/1", id.overflow, id.busy); end
  endtask

  task automatic test_abort();
    logic [63:0] seq2;
    logic [63:0] exp_w;
    do_reset();
    out_ready = 1'b1;
    send_bits(64'($urandom), 5, 1'b1, 64'h0, 0);
    send_bits(64'hFF, 8, 1'b1, 64'h0, 0);
    step();
    checks++; if (qa.size() !== 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", qa.size()); end
    else begin
      checks++; if (qa[0] !== 8'hFF) begin errors++; $display("FAIL abort_word: got %h expected ff", qa[0]); end
    end
    checks++; if (ia.overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf: got %b expected 0", ia.overflow); end
    qa.delete();
    seq2 = 64'($urandom_range(1, 255));
    send_bits(64'($urandom), 7, 1'b1, 64'h0, 0);
    send_bits(seq2, 1, 1'b1, 64'h0, 0);
    checks++; if (qa.size() !== 0 || ia.data_valid !== 1'b0 || ia.busy !== 1'b1) begin
      errors++; $display("FAIL abort_collide: words=%0d dv=%b busy=%b expected 0/0/1", qa.size(), ia.data_valid, ia.busy); end
    send_bits(seq2 >> 1, 7, 1'b0, 64'h0, 0);
    exp_w = model_word(seq2, 8, 1'b1);
    checks++; if (ia.data_valid !== 1'b1 || ia.data !== exp_w[7:0]) begin
      errors++; $display("FAIL abort_newword: dv=%b data=%h expected 1/%h", ia.data_valid, ia.data, exp_w[7:0]); end
  endtask

  task automatic test_reset_midframe();
    send_bits(64'($urandom), 4, 1'b1, 64'h0, 0);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ia.data !== 8'h0 || {ia.data_valid, ia.busy, ia.overflow} !== 3'b000) begin
      errors++; $display("FAIL midreset_a: data=%h dv/busy/ovf=%b%b%b expected 0", ia.data, ia.data_valid, ia.busy, ia.overflow); end
    checks++; if (id.busy !== 1'b0 || ic.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_busy: c=%b d=%b expected 0/0", ic.busy, id.busy); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    qa.delete();
    out_ready = 1'b1;
    send_bits(tx_seq(64'h81, 8), 8, 1'b1, 64'h0, 0);
    checks++; if (ia.data_valid !== 1'b1 || ia.data !== 8'h81) begin
      errors++; $display("FAIL midreset_fresh: dv=%b data=%h expected 1/81", ia.data_valid, ia.data); end
  endtask

  task automatic test_random();
    logic [7:0]  ea[$];
    logic [7:0]  eb[$];
    logic [31:0] ed[$];
    logic [63:0] s;
    logic [63:0] m;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      s = 64'($urandom);
      send_bits(s, 8, 1'b1, 64'h0, 2);
      m = model_word(s, 8, 1'b1); ea.push_back(m[7:0]);
      m = model_word(s, 8, 1'b0); eb.push_back(m[7:0]);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
    end
    step();
    checks++; if (qa.size() !== ea.size() || qb.size() !== eb.size()) begin
      errors++; $display("FAIL rnd_count: a=%0d b=%0d expected %0d", qa.size(), qb.size(), ea.size()); end
    for (int i = 0; i < ea.size() && i < qa.size() && i < qb.size(); i++) begin
      checks++; if (qa[i] !== ea[i] || qb[i] !== eb[i]) begin
        errors++; $display("FAIL rnd_word%0d: a=%h b=%h expected %h %h", i, qa[i], qb[i], ea[i], eb[i]); end
    end
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s = 64'($urandom);
      send_bits(tx_seq(s, 32), 32, k == 0, 64'h0, 2);
      ed.push_back(s[31:0]);
    end
    step();
    checks++; if (qd.size() !== ed.size()) begin
      errors++; $display("FAIL rnd_cont_count: got %0d expected %0d", qd.size(), ed.size()); end
    for (int i = 0; i < ed.size() && i < qd.size(); i++) begin
      checks++; if (qd[i] !== ed[i]) begin
        errors++; $display("FAIL rnd_cont_word%0d: got %h expected %h", i, qd[i], ed[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_lsb_gaps();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
